ahb_serial_dump: RTL and testbench

Memory readback transmitter: the reader counterpart of the serial program loader. On a START pulse it fetches WORD_CNT consecutive 32-bit words from AHB memory, beginning at word index BASE_ADDR, as a single-transfer AHB-Lite read master. It shifts each word out MSB-first on a framed serial link (SCK/SDO/SFRAME) so a host can verify loaded contents. A one-word holding buffer lets the next AHB read overlap the current serial shift.

---
 rtl/ahb_serial_dump.sv | 242 ++++++++++++++++++++++++
 tb/tb_ahb_serial_dump.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_serial_dump.sv
// AHB-Lite single-transfer read master that streams a block of memory words
// MSB-first over a framed SCK/SDO/SFRAME link, with one word of read-ahead.
module ahb_serial_dump #(
  parameter int unsigned CLK_DIV  = 4,
  parameter logic [31:0] ERR_WORD = 32'hBAD0_BAD0
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        START,
  input  logic [15:0] BASE_ADDR,
  input  logic [15:0] WORD_CNT,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [31:0] HWDATA,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic        HMASTLOCK,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP,
  output logic        SCK,
  output logic        SDO,
  output logic        SFRAME
);
  localparam int unsigned   PW      = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PH_LAST = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] PH_RISE = PW'(CLK_DIV / 2 - 1);

  typedef enum logic [1:0] {F_IDLE, F_ADDR, F_DATA} f_state_t;
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} s_state_t;

  f_state_t      f_q, f_d;
  s_state_t      s_q, s_d;
  logic          active_q, active_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [15:0]   idx_q, idx_d;
  logic [15:0]   words_q, words_d;
  logic          nonseq_q, nonseq_d;
  logic [15:0]   hidx_q, hidx_d;
  logic [31:0]   buf_q, buf_d;
  logic          buf_valid_q, buf_valid_d;
  logic [31:0]   sh_q, sh_d;
  logic [4:0]    bit_q, bit_d;
  logic [PW-1:0] ph_q, ph_d;
  logic          sck_q, sck_d;
  logic          sframe_q, sframe_d;
  logic          start_ok_s;
  logic          load_s;

  // Next-state logic for control, fetcher, shifter and completion.
  always_comb begin
    f_d         = f_q;
    s_d         = s_q;
    active_d    = active_q;
    done_d      = 1'b0;
    err_d       = err_q;
    idx_d       = idx_q;
    words_d     = words_q;
    nonseq_d    = nonseq_q;
    hidx_d      = hidx_q;
    buf_d       = buf_q;
    buf_valid_d = buf_valid_q;
    sh_d        = sh_q;
    bit_d       = bit_q;
    ph_d        = ph_q;
    sck_d       = sck_q;
    sframe_d    = sframe_q;
    load_s      = 1'b0;
    start_ok_s  = START & ~active_q;

    if (start_ok_s) begin
      err_d    = 1'b0;
      idx_d    = BASE_ADDR;
      words_d  = WORD_CNT;
      active_d = (WORD_CNT != 16'd0);
    end else begin
      active_d = active_q;
    end

    // A fresh START launches its first address phase directly from the inputs.
    case (f_q)
      F_IDLE: begin
        if (start_ok_s && (WORD_CNT != 16'd0)) begin
          f_d      = F_ADDR;
          nonseq_d = 1'b1;
          hidx_d   = BASE_ADDR;
        end else if (active_q && (words_q != 16'd0) && !buf_valid_q) begin
          f_d      = F_ADDR;
          nonseq_d = 1'b1;
          hidx_d   = idx_q;
        end else begin
          f_d = F_IDLE;
        end
      end
      F_ADDR: begin
        if (HREADY) begin
          f_d      = F_DATA;
          nonseq_d = 1'b0;
        end else begin
          f_d = F_ADDR;
        end
      end
      F_DATA: begin
        if (HREADY) begin
          buf_d       = HRESP ? ERR_WORD : HRDATA;
          err_d       = err_q | HRESP;
          buf_valid_d = 1'b1;
          idx_d       = idx_q + 16'd1;
          words_d     = words_q - 16'd1;
          f_d         = F_IDLE;
        end else begin
          f_d = F_DATA;
        end
      end
      default: begin
        f_d      = F_IDLE;
        nonseq_d = 1'b0;
      end
    endcase

    case (s_q)
      S_IDLE: begin
        load_s = buf_valid_q;
      end
      S_SHIFT: begin
        if (ph_q == PH_LAST) begin
          ph_d  = '0;
          sck_d = 1'b0;
          if (bit_q == 5'd31) begin
            sframe_d = 1'b0;
            sh_d     = 32'd0;
            s_d      = S_GAP;
          end else begin
            bit_d = bit_q + 5'd1;
            sh_d  = {sh_q[30:0], 1'b0};
          end
        end else begin
          ph_d  = ph_q + PW'(1);
          sck_d = (ph_q == PH_RISE) ? 1'b1 : sck_q;
        end
      end
      S_GAP: begin
        if (ph_q == PH_LAST) begin
          ph_d   = '0;
          s_d    = S_IDLE;
          load_s = buf_valid_q;
        end else begin
          ph_d = ph_q + PW'(1);
        end
      end
      default: begin
        s_d      = S_IDLE;
        sck_d    = 1'b0;
        sframe_d = 1'b0;
      end
    endcase

    // Gap end chains straight into the next frame so frames sit CLK_DIV apart.
    if (load_s) begin
      sh_d        = buf_q;
      buf_valid_d = 1'b0;
      sframe_d    = 1'b1;
      sck_d       = 1'b0;
      ph_d        = '0;
      bit_d       = 5'd0;
      s_d         = S_SHIFT;
    end else begin
      buf_valid_d = buf_valid_d;
    end

    if (start_ok_s) begin
      done_d = (WORD_CNT == 16'd0);
    end else if (active_q && (words_d == 16'd0) && (f_d == F_IDLE) &&
                 !buf_valid_d && (s_d == S_IDLE)) begin
      done_d   = 1'b1;
      active_d = 1'b0;
    end else begin
      done_d = 1'b0;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      f_q         <= F_IDLE;
      s_q         <= S_IDLE;
      active_q    <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      idx_q       <= 16'd0;
      words_q     <= 16'd0;
      nonseq_q    <= 1'b0;
      hidx_q      <= 16'd0;
      buf_q       <= 32'd0;
      buf_valid_q <= 1'b0;
      sh_q        <= 32'd0;
      bit_q       <= 5'd0;
      ph_q        <= '0;
      sck_q       <= 1'b0;
      sframe_q    <= 1'b0;
    end else begin
      f_q         <= f_d;
      s_q         <= s_d;
      active_q    <= active_d;
      done_q      <= done_d;
      err_q       <= err_d;
      idx_q       <= idx_d;
      words_q     <= words_d;
      nonseq_q    <= nonseq_d;
      hidx_q      <= hidx_d;
      buf_q       <= buf_d;
      buf_valid_q <= buf_valid_d;
      sh_q        <= sh_d;
      bit_q       <= bit_d;
      ph_q        <= ph_d;
      sck_q       <= sck_d;
      sframe_q    <= sframe_d;
    end
  end

  assign BUSY      = active_q;
  assign DONE      = done_q;
  assign ERR       = err_q;
  assign HADDR     = {8'h00, hidx_q, 2'b00};
  assign HTRANS    = {nonseq_q, 1'b0};
  assign HWRITE    = 1'b0;
  assign HWDATA    = 32'd0;
  assign HSIZE     = 3'b010;
  assign HBURST    = 3'b000;
  assign HPROT     = 4'b0011;
  assign HMASTLOCK = 1'b0;
  assign SCK       = sck_q;
  assign SDO       = sh_q[31];
  assign SFRAME    = sframe_q;

endmodule

// File: tb/tb_ahb_serial_dump.sv
// Randomized bench for ahb_serial_dump: an AHB slave with random wait states
// and errors, plus a serial frame decoder compared against expected words.
module tb_ahb_serial_dump;
  localparam int          CLK_DIV  = 4;
  localparam logic [31:0] ERR_WORD = 32'hBAD0_BAD0;

  logic        HCLK = 1'b0, HRESET = 1'b1, START = 1'b0;
  logic [15:0] BASE_ADDR = 16'd0, WORD_CNT = 16'd0;
  logic        BUSY, DONE, ERR, HWRITE, HMASTLOCK, SCK, SDO, SFRAME;
  logic [31:0] HADDR, HWDATA;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;
  logic [31:0] HRDATA = 32'd0;
  logic        HREADY = 1'b1, HRESP = 1'b0;

  ahb_serial_dump #(.CLK_DIV(CLK_DIV), .ERR_WORD(ERR_WORD)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .START(START), .BASE_ADDR(BASE_ADDR),
    .WORD_CNT(WORD_CNT), .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .HADDR(HADDR),
    .HTRANS(HTRANS), .HWRITE(HWRITE), .HWDATA(HWDATA), .HSIZE(HSIZE),
    .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HRDATA(HRDATA),
    .HREADY(HREADY), .HRESP(HRESP), .SCK(SCK), .SDO(SDO), .SFRAME(SFRAME)
  );

  initial begin
    forever #5 HCLK = ~HCLK;
  end

  int checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // memory image and expected serial words
  logic [31:0] mem [0:65535];
  logic [31:0] exp_q [$];
  logic [15:0] exp_idx = 16'd0, pend_idx = 16'd0;
  int  n_acc = 0, wait_left = 0, wmin = 0, wmax = 0;
  logic pend = 1'b0, pend_err = 1'b0, any_err = 1'b0;
  logic err_en = 1'b0, force_err_first = 1'b0, addr_stall_en = 1'b0;

  // monitor state
  int cyc = 0, frames = 0, nbits = 0, flen = 0, gap = 0, sck_hi = 0;
  int last_fall = 0, done_cyc = 0, done_cnt = 0, start_cyc = 0, rise1_cyc = 0, ns_cycles = 0;
  logic [31:0] shreg = 32'd0;
  logic held = 1'b0, sdo_bad = 1'b0, prev_sf = 1'b0, prev_sck = 1'b0, busy_seen = 1'b0;

  // AHB slave: responses are decided at the falling edge for the next rising edge
  initial begin
    forever begin
      @(negedge HCLK);
      if (HRESET) begin
        pend = 1'b0; HREADY = 1'b1; HRESP = 1'b0;
      end else begin
        if (pend) begin
          if (wait_left > 0) begin
            HREADY = 1'b0; HRESP = 1'b0; wait_left--;
          end else begin
            HREADY = 1'b1; HRESP = pend_err;
            HRDATA = pend_err ? $urandom : mem[pend_idx];
            pend = 1'b0;
          end
        end else begin
          HREADY = addr_stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
          HRESP  = 1'b0;
        end
        if (HREADY && HTRANS == 2'b10) begin
          chk("haddr", HADDR, {8'h00, exp_idx, 2'b00});
          n_acc++;
          if (n_acc > 1) chk("fetch_overlap", {31'd0, SFRAME}, 32'd1);
          pend      = 1'b1;
          pend_idx  = HADDR[17:2];
          pend_err  = (force_err_first && n_acc == 1) || (err_en && $urandom_range(0, 5) == 0);
          wait_left = $urandom_range(wmin, wmax);
          exp_q.push_back(pend_err ? ERR_WORD : mem[exp_idx]);
          any_err   = any_err | pend_err;
          exp_idx   = exp_idx + 16'd1;
        end
      end
    end
  end

  // serial frame decoder
  initial begin
    forever begin
      @(negedge HCLK);
      cyc++;
      if (HRESET) begin
        prev_sf = 1'b0; prev_sck = 1'b0; flen = 0; nbits = 0; gap = 0;
      end else begin
        if (START && !BUSY) start_cyc = cyc;
        if (BUSY) busy_seen = 1'b1;
        if (HTRANS == 2'b10) ns_cycles++;
        if (DONE) begin
          done_cnt++; done_cyc = cyc;
          chk("busy_at_done", {31'd0, BUSY}, 32'd0);
        end
        if (SFRAME) begin
          if (!prev_sf) begin
            if (frames > 0) chk("gap", gap, CLK_DIV);
            else rise1_cyc = cyc;
            flen = 0; nbits = 0; shreg = 32'd0; sdo_bad = 1'b0; sck_hi = 0;
          end
          flen++;
          if (SCK) begin
            sck_hi++;
            if (!prev_sck) begin
              shreg = {shreg[30:0], SDO}; nbits++; held = SDO;
            end else if (SDO !== held) begin
              sdo_bad = 1'b1;
            end
          end
        end else if (prev_sf) begin
          chk("frame_len", flen, 32 * CLK_DIV);
          chk("frame_bits", nbits, 32);
          chk("sck_high", sck_hi, 16 * CLK_DIV);
          chk("sdo_stable", {31'd0, sdo_bad}, 32'd0);
          if (exp_q.size() > 0) chk("frame_word", shreg, exp_q.pop_front());
          else chk("frame_extra", exp_q.size(), 1);
          frames++; last_fall = cyc; gap = 1;
        end else begin
          gap++;
        end
        prev_sf = SFRAME; prev_sck = SCK;
      end
    end
  end

  task automatic start_dump(input logic [15:0] b, input logic [15:0] c);
    @(posedge HCLK); #1;
    exp_idx = b; n_acc = 0; any_err = 1'b0; frames = 0; done_cnt = 0;
    busy_seen = 1'b0; ns_cycles = 0; exp_q.delete();
    START = 1'b1; BASE_ADDR = b; WORD_CNT = c;
    @(posedge HCLK); #1;
    START = 1'b0; BASE_ADDR = 16'($urandom); WORD_CNT = 16'($urandom);
  endtask

  task automatic mid_start(input int dly);
    repeat (dly) @(posedge HCLK);
    #1;
    if (BUSY) begin
      START = 1'b1; BASE_ADDR = 16'($urandom); WORD_CNT = 16'($urandom_range(1, 9));
      @(posedge HCLK); #1;
      START = 1'b0;
    end
  endtask

  task automatic check_tied(input string tag);
    chk({tag, "_hwdata"}, HWDATA, 32'd0);
    chk({tag, "_ctl"}, {20'd0, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK},
        {20'd0, 1'b0, 3'b010, 3'b000, 4'b0011, 1'b0});
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_outs"}, {24'd0, BUSY, DONE, ERR, SCK, SDO, SFRAME, HTRANS}, 32'd0);
    chk({tag, "_haddr"}, HADDR, 32'd0);
    check_tied(tag);
  endtask

  task automatic wait_done(input int c);
    int n = 0;
    while (done_cnt == 0 && n < 200 * c + 200) begin
      @(negedge HCLK); n++;
    end
    chk("done_seen", {31'd0, done_cnt != 0}, 32'd1);
    repeat (4) @(negedge HCLK);
    chk("done_pulses", done_cnt, 1);
    chk("frames", frames, c);
    chk("accepts", n_acc, c);
    chk("exp_left", exp_q.size(), 0);
    chk("err", {31'd0, ERR}, {31'd0, any_err});
    chk("busy_idle", {31'd0, BUSY}, 32'd0);
    if (c > 0) begin
      chk("done_after_fall", done_cyc - last_fall, CLK_DIV);
    end else begin
      chk("zero_busy", {31'd0, busy_seen}, 32'd0);
      chk("zero_done_lat", done_cyc - start_cyc, 1);
      chk("zero_nonseq", ns_cycles, 0);
    end
    check_tied("end");
  endtask

  initial begin
    int n;
    int c;
    for (int i = 0; i < 65536; i++) mem[i] = $urandom;
    mem[16'h0010] = 32'hA5C3_0F81;
    repeat (3) @(posedge HCLK);
    #1;
    check_reset("rst");
    HRESET = 1'b0;

    // single word, zero wait states
    start_dump(16'h0010, 16'd1);
    wait_done(1);
    chk("first_lat", rise1_cyc - start_cyc, 4);
    chk("nonseq_cycles", ns_cycles, 1);

    // three words, five data-phase wait states each
    wmin = 5; wmax = 5;
    start_dump(16'($urandom), 16'd3);
    wait_done(3);
    chk("burst_nonseq", ns_cycles, 3);

    // index wrap with an error on the first read, plus an ignored START
    wmin = 0; wmax = 2; force_err_first = 1'b1;
    start_dump(16'hFFFF, 16'd2);
    mid_start(150);
    wait_done(2);
    force_err_first = 1'b0;

    // zero count: also clears the sticky error
    start_dump(16'($urandom), 16'd0);
    wait_done(0);

    // randomized dumps
    err_en = 1'b1; addr_stall_en = 1'b1;
    for (int r = 0; r < 6; r++) begin
      wmax = $urandom_range(0, 8);
      c = $urandom_range(1, 4);
      start_dump((r == 2) ? 16'hFFFE : 16'($urandom), 16'(c));
      if (r % 2 == 1) mid_start($urandom_range(5, 300));
      wait_done(c);
    end

    // reset in the middle of the second frame, then a fresh dump
    err_en = 1'b0; addr_stall_en = 1'b0; wmax = 1;
    start_dump(16'($urandom), 16'd3);
    n = 0;
    while (!(frames == 1 && SFRAME && nbits == 13) && n < 2000) begin
      @(negedge HCLK); n++;
    end
    chk("reach_bit12", {31'd0, n < 2000}, 32'd1);
    @(posedge HCLK); #1;
    HRESET = 1'b1;
    @(posedge HCLK); #1;
    HRESET = 1'b0;
    check_reset("rst_mid");
    start_dump(16'($urandom), 16'd2);
    wait_done(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
